// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) arbiter onto a single-outstanding memory port.
// Optional define MEM_ARB_FAIRNESS_EN enables fetch anti-starvation after STARVE_MAX data grants.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_done,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_gnt_i;
  logic                  w_gnt_d;
  logic                  w_fetch_first;
  logic [ADDR_W-1:0]     r_addr;
  logic                  r_we;
  logic [DATA_W-1:0]     r_wdata;
  logic [DATA_W/8-1:0]   r_be;
  logic                  r_if_rvalid;
  logic [DATA_W-1:0]     r_if_rdata;
  logic                  r_d_done;
  logic [DATA_W-1:0]     r_d_rdata;

`ifdef MEM_ARB_FAIRNESS_EN
  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  logic [CNT_W-1:0] r_starve;

  // Counter only advances while fetch is waiting, so it stops at STARVE_MAX.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_starve <= '0;
    else if (w_gnt_i)
      r_starve <= '0;
    else if (w_gnt_d && if_req)
      r_starve <= r_starve + 1'b1;
  end

  assign w_fetch_first = if_req && (r_starve == CNT_W'(STARVE_MAX));
`else
  assign w_fetch_first = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_i     = 1'b0;
    w_gnt_d     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!reset) begin
          if (if_req && (w_fetch_first || !d_req)) begin
            w_gnt_i     = 1'b1;
            w_state_nxt = BUSY_I;
          end else if (d_req) begin
            w_gnt_d     = 1'b1;
            w_state_nxt = BUSY_D;
          end
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ready)
          w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_be    <= '0;
    end else if (w_gnt_i) begin
      r_addr  <= {if_addr[ADDR_W-1:2], 2'b00};
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_be    <= '1;
    end else if (w_gnt_d) begin
      r_addr  <= {d_addr[ADDR_W-1:2], 2'b00};
      r_we    <= d_we;
      r_wdata <= d_wdata;
      r_be    <= d_be;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_if_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_d_done    <= 1'b0;
      r_d_rdata   <= '0;
    end else begin
      r_if_rvalid <= (r_state == BUSY_I) && mem_ready;
      r_d_done    <= (r_state == BUSY_D) && mem_ready;
      if ((r_state == BUSY_I) && mem_ready)
        r_if_rdata <= mem_rdata;
      // Stores leave the load-data register untouched.
      if ((r_state == BUSY_D) && mem_ready && !r_we)
        r_d_rdata <= mem_rdata;
    end
  end

  assign if_gnt    = w_gnt_i;
  assign d_gnt     = w_gnt_d;
  assign if_rvalid = r_if_rvalid;
  assign if_rdata  = r_if_rdata;
  assign d_done    = r_d_done;
  assign d_rdata   = r_d_rdata;
  assign mem_req   = (r_state != IDLE);
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_be    = r_be;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: grants push expected memory/response values,
// a memory responder and an output monitor pop and compare them.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [3:0]  d_be;
  logic        if_gnt, if_rvalid, d_gnt, d_done;
  logic [31:0] if_rdata, d_rdata;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  be;
  } mem_exp_t;

  int          n_vec = 0;
  int          n_err = 0;
  int          mem_wait = 0;
  bit          idle_pulse = 1'b0;
  logic [31:0] exp_if[$];
  logic [31:0] exp_d[$];
  mem_exp_t    exp_mem[$];
  byte         glog[$];
  logic [31:0] hold_if = '0;
  logic [31:0] hold_d = '0;
  logic [31:0] last_ld = '0;
  logic [31:0] mem_model [logic [31:0]];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return (a ^ 32'hA5A5_0000) + 32'h11;
  endfunction

  // memory responder: ready after mem_wait cycles of mem_req
  initial begin
    int cnt = 0;
    mem_exp_t e;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (idle_pulse) begin
        mem_ready = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
      end else if (mem_req && !reset) begin
        if (cnt >= mem_wait) begin
          cnt = 0;
          mem_ready = 1'b1;
          mem_rdata = mem_val(mem_addr);
          if (exp_mem.size() == 0) begin
            chk("mem_req_spurious", mem_req, 1'b0);
          end else begin
            e = exp_mem.pop_front();
            chk("mem_addr", mem_addr, e.addr);
            chk("mem_we", mem_we, e.we);
            chk("mem_be", mem_be, e.be);
            if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
          end
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // output monitor: pushes expectations on grants, checks responses and holds
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_if.delete(); exp_d.delete(); exp_mem.delete();
        hold_if = '0; hold_d = '0; last_ld = '0;
      end else begin
        chk("gnt_onehot", if_gnt & d_gnt, 1'b0);
        if (if_gnt) begin
          exp_if.push_back(mem_val(if_addr & ~32'h3));
          exp_mem.push_back('{if_addr & ~32'h3, 1'b0, 32'h0, 4'hF});
          glog.push_back(8'h49);
        end
        if (d_gnt) begin
          if (!d_we) last_ld = mem_val(d_addr & ~32'h3);
          exp_d.push_back(last_ld);
          exp_mem.push_back('{d_addr & ~32'h3, d_we, d_wdata, d_be});
          glog.push_back(8'h44);
        end
        if (if_rvalid) begin
          if (exp_if.size() == 0) chk("if_rvalid_spurious", if_rvalid, 1'b0);
          else begin
            hold_if = exp_if.pop_front();
            chk("if_rdata", if_rdata, hold_if);
          end
        end else chk("if_rdata_hold", if_rdata, hold_if);
        if (d_done) begin
          if (exp_d.size() == 0) chk("d_done_spurious", d_done, 1'b0);
          else begin
            hold_d = exp_d.pop_front();
            chk("d_rdata", d_rdata, hold_d);
          end
        end else chk("d_rdata_hold", d_rdata, hold_d);
      end
    end
  end

  task automatic wait_gnt(input bit is_d, output int cyc);
    logic g = 1'b0;
    cyc = -1;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      g = is_d ? d_gnt : if_gnt;
      if (g) begin
        cyc = n;
        return;
      end
    end
    chk("gnt_timeout", g, 1'b1);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      ok = (exp_if.size() == 0) && (exp_d.size() == 0) && (exp_mem.size() == 0) && !mem_req;
    end
    chk("idle_timeout", ok, 1'b1);
  endtask

  task automatic xact(input string tag, input bit is_d, input bit we, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] be, input int wt);
    int cyc;
    @(posedge clk); #1;
    mem_wait = wt;
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; d_be = be;
    end else begin
      if_req = 1'b1; if_addr = a;
    end
    wait_gnt(is_d, cyc);
    chk({tag, "_gnt_lat"}, cyc, 0);
    @(posedge clk); #1;
    if_req = 1'b0; d_req = 1'b0;
    wait_idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int    cyc;
    string exp_order;
    mem_model[32'h10]  = 32'h2008_0005;
    mem_model[32'h100] = 32'h1234_5678;

    reset = 1'b1; if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    if_addr = 32'h4; d_addr = 32'h8; d_wdata = '0; d_be = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_if_gnt", if_gnt, 1'b0);
    chk("rst_d_gnt", d_gnt, 1'b0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_be", mem_be, 4'h0);
    chk("rst_if_rvalid", if_rvalid, 1'b0);
    chk("rst_d_done", d_done, 1'b0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    if_req = 1'b0; d_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;

    // fetch with two wait cycles, unaligned address
    xact("fetch13", 1'b0, 1'b0, 32'h13, 32'h0, 4'h0, 2);

    // simultaneous requests: data first, fetch granted alongside d_done
    @(posedge clk); #1;
    mem_wait = 1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_be = 4'hF;
    if_req = 1'b1; if_addr = 32'h24;
    wait_gnt(1'b1, cyc);
    chk("sim_d_gnt_lat", cyc, 0);
    chk("sim_if_gnt_low", if_gnt, 1'b0);
    @(posedge clk); #1;
    d_req = 1'b0;
    wait_gnt(1'b0, cyc);
    chk("sim_if_gnt_lat", cyc, 2);
    chk("sim_done_with_if_gnt", d_done, 1'b1);
    @(posedge clk); #1;
    if_req = 1'b0;
    wait_idle();

    // store: d_rdata must keep the earlier load value
    xact("store200", 1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF, 4'h3, 0);

    // mixed traffic with varying waits and misaligned addresses
    for (int i = 0; i < 6; i++) begin
      xact($sformatf("mix%0d", i), (i % 3) != 0, (i % 3) == 2,
           32'h1000 + 32'(i * 36 + i), 32'hC0DE_0000 + 32'(i), 4'(i + 5), i % 3);
    end

    // ready pulse while idle must be ignored
    @(posedge clk); #1;
    idle_pulse = 1'b1;
    @(posedge clk); #1;
    idle_pulse = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_ready_mem_req", mem_req, 1'b0);
    chk("idle_ready_if_rvalid", if_rvalid, 1'b0);
    chk("idle_ready_d_done", d_done, 1'b0);

    // reset during a data access abandons it
    @(posedge clk); #1;
    mem_wait = 6;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; d_be = 4'hF;
    wait_gnt(1'b1, cyc);
    chk("rstmid_gnt_lat", cyc, 0);
    @(posedge clk); #1;
    d_req = 1'b0;
    @(posedge clk); #1;
    chk("rstmid_busy", mem_req, 1'b1);
    reset = 1'b1;
    #1;
    chk("rstmid_mem_req", mem_req, 1'b0);
    chk("rstmid_mem_addr", mem_addr, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    mem_wait = 1;
    if_req = 1'b1; if_addr = 32'h80;
    wait_gnt(1'b0, cyc);
    chk("rstmid_if_gnt_lat", cyc, 0);
    @(posedge clk); #1;
    if_req = 1'b0;
    wait_idle();

    // both requesters held high: grant order
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    glog.delete();
    mem_wait = 0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400; d_be = 4'hF;
    if_req = 1'b1; if_addr = 32'h40;
    for (int n = 0; n < 200 && glog.size() < 10; n++) @(negedge clk);
    @(posedge clk); #1;
    d_req = 1'b0; if_req = 1'b0;
    wait_idle();
`ifdef MEM_ARB_FAIRNESS_EN
    exp_order = "DDDDIDDDDI";
`else
    exp_order = "DDDDDDDDDD";
`endif
    chk("order_count_ok", glog.size() >= 10, 1'b1);
    for (int i = 0; i < 10; i++) begin
      if (i < glog.size()) chk($sformatf("order%0d", i), glog[i], exp_order[i]);
    end

    chk("end_if_queue", exp_if.size(), 0);
    chk("end_d_queue", exp_d.size(), 0);
    chk("end_mem_queue", exp_mem.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
